// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and an SRAM-like data bus (addr_ok/data_ok).
// Decodes one-hot memory ops into bus fields and keeps in-flight accesses in
// program order. It extracts and extends load data (including the LWL/LWR merge)
// and reports misaligned accesses as AdEL/AdES without using the bus.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int OUTSTANDING = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [11:0]       req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [31:0]       resp_data,
    output logic              resp_exc,
    output logic [4:0]        resp_exccode,
    output logic [ADDR_W-1:0] resp_badvaddr,
    output logic              busy
);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    localparam int OP_LWL = 11;
    localparam int OP_LWR = 10;
    localparam int OP_SWL = 9;
    localparam int OP_SWR = 8;
    localparam int OP_LB  = 7;
    localparam int OP_LBU = 6;
    localparam int OP_LH  = 5;
    localparam int OP_LHU = 4;
    localparam int OP_LW  = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // request decode
    logic [1:0]        w_off;
    logic [4:0]        w_shl;
    logic [4:0]        w_shr;
    logic [3:0]        w_strb;
    logic [31:0]       w_wdata;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic              w_is_store;
    logic              w_misalign;
    logic              w_accept;
    logic              w_exc_push;
    logic              w_issue;

    // issue stage
    logic              r_pend;
    logic              r_iss_killed;
    logic [11:0]       r_iss_op;
    logic [ADDR_W-1:0] r_iss_addr;
    logic [31:0]       r_iss_rt;
    logic              r_data_req;
    logic              r_data_wr;
    logic [1:0]        r_data_size;
    logic [ADDR_W-1:0] r_data_addr;
    logic [3:0]        r_data_wstrb;
    logic [31:0]       r_data_wdata;

    // in-order entry FIFO
    logic [11:0]       r_f_op     [OUTSTANDING];
    logic [ADDR_W-1:0] r_f_addr   [OUTSTANDING];
    logic [31:0]       r_f_rt     [OUTSTANDING];
    logic              r_f_exc    [OUTSTANDING];
    logic              r_f_killed [OUTSTANDING];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_nbus;
    logic [CW-1:0]     r_nack;

    logic              w_push_bus;
    logic              w_push;
    logic              w_bus_ok;
    logic              w_pop;
    logic              w_pop_bus;
    logic              w_rsp;

    // head view and load extraction
    logic [11:0]       w_h_op;
    logic [ADDR_W-1:0] w_h_addr;
    logic [31:0]       w_h_rt;
    logic              w_h_exc;
    logic              w_h_killed;
    logic [1:0]        w_h_off;
    logic [4:0]        w_h_shl;
    logic [4:0]        w_h_shr;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic              w_h_is_load;
    logic              w_h_is_store;

    // response registers
    logic              r_resp_valid;
    logic              r_resp_we;
    logic [31:0]       r_resp_data;
    logic              r_resp_exc;
    logic [4:0]        r_resp_exccode;
    logic [ADDR_W-1:0] r_resp_badvaddr;

    // decode the presented op into strobes, aligned store data, size and bus address
    always_comb begin
        w_off      = req_addr[1:0];
        w_shl      = {w_off, 3'b000};
        w_shr      = {~w_off, 3'b000};
        w_strb     = 4'b0000;
        w_wdata    = '0;
        w_size     = 2'd2;
        w_addr     = req_addr;
        w_is_store = req_op[OP_SWL] | req_op[OP_SWR] | req_op[OP_SB] | req_op[OP_SH] | req_op[OP_SW];
        if (req_op[OP_LB] | req_op[OP_LBU] | req_op[OP_SB]) begin
            w_strb = 4'b0001 << w_off;
            w_size = 2'd0;
        end else if (req_op[OP_LH] | req_op[OP_LHU] | req_op[OP_SH]) begin
            w_strb = w_off[1] ? 4'b1100 : 4'b0011;
            w_size = 2'd1;
        end else if (req_op[OP_LWL] | req_op[OP_SWL]) begin
            w_strb = 4'b1111 >> (~w_off);
            w_addr = {req_addr[ADDR_W-1:2], 2'b00};
        end else if (req_op[OP_LWR] | req_op[OP_SWR]) begin
            w_strb = 4'b1111 << w_off;
        end else if (req_op[OP_LW] | req_op[OP_SW]) begin
            w_strb = 4'b1111;
        end
        if (req_op[OP_SB])  w_wdata = {4{req_wdata[7:0]}};
        if (req_op[OP_SH])  w_wdata = {2{req_wdata[15:0]}};
        if (req_op[OP_SW])  w_wdata = req_wdata;
        if (req_op[OP_SWL]) w_wdata = req_wdata >> w_shr;
        if (req_op[OP_SWR]) w_wdata = req_wdata << w_shl;
        w_misalign = (ALIGN_CHECK != 0) &&
                     (((req_op[OP_LH] | req_op[OP_LHU] | req_op[OP_SH]) && w_off[0]) ||
                      ((req_op[OP_LW] | req_op[OP_SW]) && (w_off != 2'b00)));
    end

    assign req_ready  = !flush && !r_pend && (r_count != CW'(OUTSTANDING));
    assign w_accept   = req_valid && req_ready;
    assign w_exc_push = w_accept && (|req_op) && w_misalign;
    assign w_issue    = w_accept && (|req_op) && !w_misalign;

    // issue stage: hold the bus request stable until the address is taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend       <= 1'b0;
            r_iss_killed <= 1'b0;
            r_iss_op     <= '0;
            r_iss_addr   <= '0;
            r_iss_rt     <= '0;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_size  <= '0;
            r_data_addr  <= '0;
            r_data_wstrb <= '0;
            r_data_wdata <= '0;
        end else if (w_issue) begin
            r_pend       <= 1'b1;
            r_iss_killed <= 1'b0;
            r_iss_op     <= req_op;
            r_iss_addr   <= req_addr;
            r_iss_rt     <= req_wdata;
            r_data_req   <= 1'b1;
            r_data_wr    <= w_is_store;
            r_data_size  <= w_size;
            r_data_addr  <= w_addr;
            r_data_wstrb <= w_strb;
            r_data_wdata <= w_wdata;
        end else if (r_pend && data_addr_ok) begin
            r_pend     <= 1'b0;
            r_data_req <= 1'b0;
        end else if (r_pend && flush) begin
            r_iss_killed <= 1'b1;
        end
    end

    assign data_req   = r_data_req;
    assign data_wr    = r_data_wr;
    assign data_size  = r_data_size;
    assign data_addr  = r_data_addr;
    assign data_wstrb = r_data_wstrb;
    assign data_wdata = r_data_wdata;

    // A data_ok counts only if a bus entry is waiting for it. Acks that arrive while an
    // exception entry blocks the head are banked in r_nack so none are lost.
    assign w_push_bus = r_pend && data_addr_ok;
    assign w_push     = w_exc_push || w_push_bus;
    assign w_h_exc    = r_f_exc[r_rd];
    assign w_h_killed = r_f_killed[r_rd];
    assign w_bus_ok   = data_data_ok && (r_nbus != r_nack);
    assign w_pop      = (r_count != '0) && (w_h_exc || (r_nack != '0) || w_bus_ok);
    assign w_pop_bus  = w_pop && !w_h_exc;
    assign w_rsp      = w_pop && !w_h_killed && !flush;

    // entry FIFO, kill marking and bus/ack bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_f_op[i]     <= '0;
                r_f_addr[i]   <= '0;
                r_f_rt[i]     <= '0;
                r_f_exc[i]    <= 1'b0;
                r_f_killed[i] <= 1'b0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_nbus  <= '0;
            r_nack  <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < OUTSTANDING; i++) r_f_killed[i] <= 1'b1;
            end
            if (w_push) begin
                r_f_op[r_wr]     <= w_exc_push ? req_op : r_iss_op;
                r_f_addr[r_wr]   <= w_exc_push ? req_addr : r_iss_addr;
                r_f_rt[r_wr]     <= w_exc_push ? req_wdata : r_iss_rt;
                r_f_exc[r_wr]    <= w_exc_push;
                r_f_killed[r_wr] <= w_exc_push ? 1'b0 : (r_iss_killed | flush);
                r_wr             <= f_next(r_wr);
            end
            if (w_pop) r_rd <= f_next(r_rd);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_push_bus && !w_pop_bus)      r_nbus <= r_nbus + CW'(1);
            else if (!w_push_bus && w_pop_bus) r_nbus <= r_nbus - CW'(1);
            if (w_bus_ok && !w_pop_bus)      r_nack <= r_nack + CW'(1);
            else if (!w_bus_ok && w_pop_bus) r_nack <= r_nack - CW'(1);
        end
    end

    // extract and extend load data for the head entry
    always_comb begin
        w_h_op       = r_f_op[r_rd];
        w_h_addr     = r_f_addr[r_rd];
        w_h_rt       = r_f_rt[r_rd];
        w_h_off      = w_h_addr[1:0];
        w_h_shl      = {w_h_off, 3'b000};
        w_h_shr      = {~w_h_off, 3'b000};
        w_byte       = 8'(data_rdata >> w_h_shl);
        w_half       = w_h_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        w_h_is_load  = w_h_op[OP_LWL] | w_h_op[OP_LWR] | w_h_op[OP_LB] | w_h_op[OP_LBU] |
                       w_h_op[OP_LH] | w_h_op[OP_LHU] | w_h_op[OP_LW];
        w_h_is_store = w_h_op[OP_SWL] | w_h_op[OP_SWR] | w_h_op[OP_SB] | w_h_op[OP_SH] |
                       w_h_op[OP_SW];
        w_load_data  = '0;
        if (w_h_op[OP_LB])  w_load_data = {{24{w_byte[7]}}, w_byte};
        if (w_h_op[OP_LBU]) w_load_data = {24'h0, w_byte};
        if (w_h_op[OP_LH])  w_load_data = {{16{w_half[15]}}, w_half};
        if (w_h_op[OP_LHU]) w_load_data = {16'h0, w_half};
        if (w_h_op[OP_LW])  w_load_data = data_rdata;
        if (w_h_op[OP_LWL]) w_load_data = (data_rdata << w_h_shr) | (w_h_rt & (32'h00FF_FFFF >> w_h_shl));
        if (w_h_op[OP_LWR]) w_load_data = (data_rdata >> w_h_shl) | (w_h_rt & ~(32'hFFFF_FFFF >> w_h_shl));
    end

    // register the response for the popped entry; fields read zero when not valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_valid    <= 1'b0;
            r_resp_we       <= 1'b0;
            r_resp_data     <= '0;
            r_resp_exc      <= 1'b0;
            r_resp_exccode  <= '0;
            r_resp_badvaddr <= '0;
        end else begin
            r_resp_valid    <= w_rsp;
            r_resp_we       <= w_rsp && !w_h_exc && w_h_is_load;
            r_resp_data     <= (w_rsp && !w_h_exc && w_h_is_load) ? w_load_data : '0;
            r_resp_exc      <= w_rsp && w_h_exc;
            r_resp_exccode  <= (w_rsp && w_h_exc) ? (w_h_is_store ? 5'h05 : 5'h04) : 5'h00;
            r_resp_badvaddr <= (w_rsp && w_h_exc) ? w_h_addr : '0;
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_we       = r_resp_we;
    assign resp_data     = r_resp_data;
    assign resp_exc      = r_resp_exc;
    assign resp_exccode  = r_resp_exccode;
    assign resp_badvaddr = r_resp_badvaddr;
    assign busy          = (r_count != '0) || r_pend;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus fields, load extraction, address
// errors, FIFO back-pressure, flush and reset behaviour.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        resp_valid;
    logic        resp_we;
    logic [31:0] resp_data;
    logic        resp_exc;
    logic [4:0]  resp_exccode;
    logic [31:0] resp_badvaddr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] LWL = 12'h800, LWR = 12'h400, SWL = 12'h200, SWR = 12'h100;
    localparam logic [11:0] LB  = 12'h080, LBU = 12'h040, LH  = 12'h020, LHU = 12'h010;
    localparam logic [11:0] LW  = 12'h008, SB  = 12'h004, SH  = 12'h002, SW  = 12'h001;

    mem_access_unit #(.ADDR_W(32), .OUTSTANDING(2), .ALIGN_CHECK(1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_data(resp_data),
        .resp_exc(resp_exc), .resp_exccode(resp_exccode), .resp_badvaddr(resp_badvaddr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one complete access with immediate addr_ok and data_ok
    task automatic xact(input string tag, input logic [11:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [1:0] e_size,
                        input logic e_wr, input logic e_we, input logic [31:0] e_resp);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = rt;
        chk({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; req_op = '0; req_wdata = 32'h0;
        chk({tag, "/req"},   {31'b0, data_req}, 32'd1);
        chk({tag, "/addr"},  data_addr, e_addr);
        chk({tag, "/strb"},  {28'b0, data_wstrb}, {28'b0, e_strb});
        chk({tag, "/wdata"}, data_wdata, e_wdata);
        chk({tag, "/size"},  {30'b0, data_size}, {30'b0, e_size});
        chk({tag, "/wr"},    {31'b0, data_wr}, {31'b0, e_wr});
        chk({tag, "/rdy_pend"}, {31'b0, req_ready}, 32'd0);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk({tag, "/req_drop"}, {31'b0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = rdata;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        chk({tag, "/rvalid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "/rwe"},    {31'b0, resp_we}, {31'b0, e_we});
        chk({tag, "/rexc"},   {31'b0, resp_exc}, 32'd0);
        if (e_we) chk({tag, "/rdata"}, resp_data, e_resp);
        tick();
        chk({tag, "/rvalid_end"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "/busy_end"},   {31'b0, busy}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_wdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        tick();
        chk("rst/data_req",   {31'b0, data_req}, 32'd0);
        chk("rst/resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst/resp_exc",   {31'b0, resp_exc}, 32'd0);
        chk("rst/busy",       {31'b0, busy}, 32'd0);
        chk("rst/wstrb",      {28'b0, data_wstrb}, 32'd0);
        chk("rst/ready",      {31'b0, req_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        // directed vectors: bus fields and extracted load data
        xact("sb",  SB,  32'h1003, 32'h12345678, 32'h0,        32'h1003, 4'b1000, 32'h78787878, 2'd0, 1'b1, 1'b0, 32'h0);
        xact("lb",  LB,  32'h2001, 32'h0,        32'h00008000, 32'h2001, 4'b0010, 32'h0,        2'd0, 1'b0, 1'b1, 32'hFFFFFF80);
        xact("lbu", LBU, 32'h2001, 32'h0,        32'h00008000, 32'h2001, 4'b0010, 32'h0,        2'd0, 1'b0, 1'b1, 32'h00000080);
        xact("lh",  LH,  32'h2002, 32'h0,        32'h80010000, 32'h2002, 4'b1100, 32'h0,        2'd1, 1'b0, 1'b1, 32'hFFFF8001);
        xact("lhu", LHU, 32'h2000, 32'h0,        32'h1234F00D, 32'h2000, 4'b0011, 32'h0,        2'd1, 1'b0, 1'b1, 32'h0000F00D);
        xact("lwl", LWL, 32'h3001, 32'hAABBCCDD, 32'h11223344, 32'h3000, 4'b0011, 32'h0,        2'd2, 1'b0, 1'b1, 32'h3344CCDD);
        xact("lwr", LWR, 32'h3002, 32'hAABBCCDD, 32'h11223344, 32'h3002, 4'b1100, 32'h0,        2'd2, 1'b0, 1'b1, 32'hAABB1122);
        xact("swl", SWL, 32'h5002, 32'hAABBCCDD, 32'h0,        32'h5000, 4'b0111, 32'h00AABBCC, 2'd2, 1'b1, 1'b0, 32'h0);
        xact("swr", SWR, 32'h5001, 32'hAABBCCDD, 32'h0,        32'h5001, 4'b1110, 32'hBBCCDD00, 2'd2, 1'b1, 1'b0, 32'h0);
        xact("sh",  SH,  32'h6002, 32'h12345678, 32'h0,        32'h6002, 4'b1100, 32'h56785678, 2'd1, 1'b1, 1'b0, 32'h0);

        // stray data_ok with nothing outstanding is ignored
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("stray/rvalid", {31'b0, resp_valid}, 32'd0);
        chk("stray/busy",   {31'b0, busy}, 32'd0);
        xact("lw",  LW,  32'h7000, 32'h0,        32'hDEADBEEF, 32'h7000, 4'b1111, 32'h0,        2'd2, 1'b0, 1'b1, 32'hDEADBEEF);

        // all-zero op is accepted and dropped
        req_valid = 1'b1; req_op = '0; req_addr = 32'h7777;
        tick();
        req_valid = 1'b0;
        chk("nop/req",  {31'b0, data_req}, 32'd0);
        chk("nop/busy", {31'b0, busy}, 32'd0);

        // misaligned LW: no bus request, AdEL
        req_valid = 1'b1; req_op = LW; req_addr = 32'h4002;
        tick();
        req_valid = 1'b0; req_op = '0;
        chk("adel/req",  {31'b0, data_req}, 32'd0);
        chk("adel/busy", {31'b0, busy}, 32'd1);
        tick();
        chk("adel/req2",   {31'b0, data_req}, 32'd0);
        chk("adel/rvalid", {31'b0, resp_valid}, 32'd1);
        chk("adel/rexc",   {31'b0, resp_exc}, 32'd1);
        chk("adel/code",   {27'b0, resp_exccode}, 32'h04);
        chk("adel/bad",    resp_badvaddr, 32'h4002);
        chk("adel/we",     {31'b0, resp_we}, 32'd0);
        tick();
        chk("adel/rvalid_end", {31'b0, resp_valid}, 32'd0);
        chk("adel/busy_end",   {31'b0, busy}, 32'd0);

        // misaligned SW queued behind an in-flight load: load responds first
        req_valid = 1'b1; req_op = LW; req_addr = 32'h8000;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        req_valid = 1'b1; req_op = SW; req_addr = 32'h8001; req_wdata = 32'h5555AAAA;
        chk("ades/ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; req_op = '0;
        chk("ades/full_rdy", {31'b0, req_ready}, 32'd0);
        chk("ades/no_rsp",   {31'b0, resp_valid}, 32'd0);
        chk("ades/no_req",   {31'b0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0BADF00D;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        chk("ades/ld_valid", {31'b0, resp_valid}, 32'd1);
        chk("ades/ld_exc",   {31'b0, resp_exc}, 32'd0);
        chk("ades/ld_data",  resp_data, 32'h0BADF00D);
        tick();
        chk("ades/ex_valid", {31'b0, resp_valid}, 32'd1);
        chk("ades/ex_exc",   {31'b0, resp_exc}, 32'd1);
        chk("ades/ex_code",  {27'b0, resp_exccode}, 32'h05);
        chk("ades/ex_bad",   resp_badvaddr, 32'h8001);
        tick();
        chk("ades/end_valid", {31'b0, resp_valid}, 32'd0);
        chk("ades/end_busy",  {31'b0, busy}, 32'd0);

        // two loads in flight block a third op until the first data_ok
        req_valid = 1'b1; req_op = LW; req_addr = 32'h9000;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        req_valid = 1'b1; req_addr = 32'h9004;
        chk("full/rdy_b", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        req_valid = 1'b1; req_addr = 32'h9008;
        chk("full/rdy0", {31'b0, req_ready}, 32'd0);
        tick();
        chk("full/rdy1", {31'b0, req_ready}, 32'd0);
        chk("full/noreq", {31'b0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h11111111;
        tick();
        data_data_ok = 1'b0;
        chk("full/a_data", resp_data, 32'h11111111);
        chk("full/a_valid", {31'b0, resp_valid}, 32'd1);
        chk("full/rdy_back", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("full/c_req",  {31'b0, data_req}, 32'd1);
        chk("full/c_addr", data_addr, 32'h9008);
        data_data_ok = 1'b1; data_rdata = 32'h22222222;
        tick();
        data_data_ok = 1'b0;
        chk("full/b_data", resp_data, 32'h22222222);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h33333333;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        chk("full/c_data", resp_data, 32'h33333333);
        tick();
        chk("full/busy_end", {31'b0, busy}, 32'd0);

        // flush after two addr_oks: both data_oks consumed silently
        req_valid = 1'b1; req_op = LW; req_addr = 32'hA000;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        req_valid = 1'b1; req_addr = 32'hA004;
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1; req_valid = 1'b1; req_op = LB; req_addr = 32'hA008;
        chk("flush/rdy", {31'b0, req_ready}, 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0; req_op = '0;
        chk("flush/not_taken", {31'b0, data_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("flush/quiet", {31'b0, resp_valid}, 32'd0);
        end
        data_data_ok = 1'b1; data_rdata = 32'hCAFE0001;
        tick();
        chk("flush/killed_a", {31'b0, resp_valid}, 32'd0);
        data_rdata = 32'hCAFE0002;
        tick();
        data_data_ok = 1'b0; data_rdata = '0;
        chk("flush/killed_b", {31'b0, resp_valid}, 32'd0);
        chk("flush/busy",     {31'b0, busy}, 32'd0);
        chk("flush/ready",    {31'b0, req_ready}, 32'd1);
        tick();
        chk("flush/killed_end", {31'b0, resp_valid}, 32'd0);

        // reset in the middle of a pending request clears everything
        req_valid = 1'b1; req_op = LW; req_addr = 32'hB000;
        tick();
        req_valid = 1'b0; req_op = '0;
        chk("mrst/req_pre", {31'b0, data_req}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mrst/req",  {31'b0, data_req}, 32'd0);
        chk("mrst/busy", {31'b0, busy}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("mrst/ready", {31'b0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised load/store unit between the EX/MEM pipeline stage and the data-side SRAM-like bus. It decodes one-hot memory ops into byte strobes, aligned write data and transfer size, and issues bus transactions with an addr_ok/data_ok handshake. It tracks up to OUTSTANDING in-flight accesses in order, then extracts and sign/zero-extends load data (including LWL/LWR merge) for write-back. With ALIGN_CHECK set, it detects misaligned addresses and reports AdEL/AdES without touching the bus.

Parameters:
ADDR_W, 32, bus/virtual address width.
OUTSTANDING, 2, in-flight entry FIFO depth (power of two, >=1).
ALIGN_CHECK, 1, 1 = trap misaligned LH/LHU/LW/SH/SW; 0 = issue them unchanged.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  kill all not-yet-responded accesses (exception/eret)
req_valid  in  1  EX presents a memory op
req_ready  out  1  unit accepts op this cycle
req_op  in  12  one-hot {lwl,lwr,swl,swr,lb,lbu,lh,lhu,lw,sb,sh,sw}
req_addr  in  ADDR_W  effective address
req_wdata  in  32  rt value (store data / LWL-LWR merge source)
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 byte, 1 half, 2 word
data_addr  out  ADDR_W  bus address
data_wstrb  out  4  byte strobes
data_wdata  out  32  aligned store data
data_addr_ok  in  1  bus accepted address
data_data_ok  in  1  bus returns data / store done
data_rdata  in  32  load data
resp_valid  out  1  one completed access, single-cycle pulse
resp_we  out  1  response carries register write data (loads only)
resp_data  out  32  final load result
resp_exc  out  1  address error
resp_exccode  out  5  0x04 AdEL, 0x05 AdES
resp_badvaddr  out  ADDR_W  faulting address
busy  out  1  FIFO non-empty or issue pending

Behaviour:
- Reset (asynchronous): data_req=0, resp_valid=0, resp_exc=0, busy=0, FIFO empty, every other registered output 0.
- req_ready = !flush && !issue_pending && FIFO not full.
- Transfer on req_valid&&req_ready. Exactly one op bit is set; an all-zero op is accepted and dropped.
- Strobes/wdata: SB strobe 1<<a[1:0], wdata {4{rt[7:0]}}. SH strobe 0011 (a[1]=0) or 1100, wdata {2{rt[15:0]}}. SW strobe 1111.
- SWL at off k: addr aligned, strobe low k+1 bytes, wdata rt>>(8*(3-k)).
- SWR at off k: addr unaligned, strobe 1111<<k, wdata rt<<(8*k).
- Loads drive the same strobes with data_wr=0 and wdata=0. LWL/LWR/SWL/SWR use size 2.
- Misaligned (ALIGN_CHECK=1): LH/LHU/SH with a[0]=1, LW/SW with a[1:0]!=0. No bus request. An exc entry is pushed directly into the FIFO; it becomes resp_exc=1 when it reaches the head.
- Issue: an accepted non-exc op registers into the issue stage; data_req=1 from the next cycle. Bus fields are held stable until data_addr_ok. On addr_ok the entry {op, offset, rt, killed} is pushed and data_req drops in the same edge. Back-to-back: a new op is accepted the cycle after addr_ok.
- Completion (strictly in order): the head pops on data_data_ok, or immediately when head.exc. resp_* is registered and valid one cycle after the pop.
- Load extract: LB/LBU byte at off, sign/zero-extended. LH/LHU half at off[1], sign/zero-extended. LW full word.
- LWL off k: {rdata[8k+7:0], rt[23-8k:0]} (k=3: rdata).
- LWR off k: {rt[31:32-8k], rdata[31:8k]} (k=0: rdata).
- Stores: resp_valid=1, resp_we=0.
- flush:
  - All FIFO entries and any pending issue are marked killed.
  - A pending data_req stays asserted until addr_ok; the request is never withdrawn.
  - Killed entries still consume their data_ok but produce no resp_valid.
  - A flush with an op at req_valid does not accept it.
- data_data_ok with the FIFO empty (or the head only queued in the same cycle) is ignored.
- FIFO full: req_ready=0. Push and pop in the same cycle at full are allowed only for the pending issue, since its push follows a pop.
- Reset mid-transaction clears everything. The bus side is reset together with the unit.

Test Plan:
- SB rt=0x12345678 at 0x1003 -> data_req next cycle, wstrb=1000, wdata=0x78787878, size 0; after data_ok, resp_valid, resp_we=0.
- LB at 0x2001, rdata=0x0000_8000 -> resp_data=0xFFFFFF80; LBU same -> 0x00000080; LH at 0x2002, rdata=0x8001_0000 -> 0xFFFF8001.
- LWL at 0x3001, rt=0xAABBCCDD, rdata=0x11223344 -> strobe 0011, addr 0x3000, resp 0x3344CCDD. LWR at 0x3002 -> strobe 1100, resp 0xAABB1122.
- LW at 0x4002 with ALIGN_CHECK=1 -> no data_req, resp_exc=1, exccode 0x04, badvaddr 0x4002. Same with a store queued behind an in-flight load -> the exception response follows the load response.
- Two loads issued back-to-back with data_ok delayed 3 cycles, then flush raised after the second addr_ok -> neither produces resp_valid, both data_ok consumed, busy=0 afterwards, req_ready=1.
- Third op while OUTSTANDING=2 entries in flight -> req_ready=0 until the first data_ok.
